integer_multiplier: RTL
=======================

# integer_multiplier

Sequential shift-and-add unsigned integer multiplier; the inverse-operation companion to the team's restoring `divider`. It uses the same go/done handshake and `cs` state-observation port, so the two blocks can share bench infrastructure. Multiplier and divider results are cross-checked against each other in the datapath test harness (q·d + r = dividend). One multiplier bit is processed per clock.

## Interface

- `WIDTH`, 4, operand width in bits; product is 2·`WIDTH`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request, sampled only in IDLE.
- `multiplicand`  in  `WIDTH`  unsigned operand A.
- `multiplier`  in  `WIDTH`  unsigned operand B.
- `product`  out  2·`WIDTH`  unsigned A·B; valid while `done`=1.
- `done`  out  1  result-valid strobe, high for exactly one cycle per operation.
- `cs`  out  4  current state encoding, for debug/bench: IDLE=0, CALC=1, DONE=2.

## Operation

- Internal regs: accumulator P (2W), shifted multiplicand S (2W), remaining multiplier M (W), iteration counter (enough bits for W).
- IDLE: `done`=0. If `go`=1 at edge:
  - S ← zero-extended `multiplicand`; M ← `multiplier`; P ← 0; counter ← 0; next state CALC.
  - Otherwise remain in IDLE.
- CALC, each edge:
  - if M[0]=1, P ← P + S (2W-bit add, cannot overflow);
  - S ← S<<1; M ← M>>1; counter ← counter+1;
  - next state DONE when counter = W−1, else CALC.
- DONE: `done`=1, `product`=P. Next edge returns unconditionally to IDLE.
- `product` is driven from P at all times. It holds its last value through IDLE until the next `go` capture clears P.
- `go` is ignored in CALC and DONE. Operand inputs are ignored after the capture edge; changing them mid-operation has no effect.
- `go` held permanently high gives back-to-back operations. IDLE lasts one cycle between each DONE and the next capture.
- No error condition exists: every operand pair, including 0, is legal.

## Timing

- Reset: asynchronous assertion (`rst`=0) forces immediately:
  - state IDLE, `cs`=0, `done`=0, `product`=0;
  - S, M and counter cleared.
- Deassertion is synchronous to `clk` by system convention; the first `go` sample is the first edge after deassertion.
- Reset mid-CALC or in DONE aborts the operation. No `done` is produced for the aborted operation.
- Latency (macro off), with the capture edge as edge 0:
  - CALC during edges 1..W;
  - DONE (`done`=1) from after edge W until edge W+1;
  - IDLE after edge W+1.
- Throughput with `go` held high: one result per W+2 cycles.
- `cs` changes only on clock edges, except for asynchronous reset.

## Configuration

- `MULT_EARLY_EXIT_EN` defined:
  - In CALC, the next state is DONE when counter = W−1 or when the post-shift M is all zero.
  - In IDLE, capturing `multiplier`=0 goes directly to DONE with P=0, so `done` is high one cycle after capture.
  - Latency becomes (index of highest set bit of B)+1 CALC cycles, plus DONE.
  - `product` values are identical to the macro-off build.
- `MULT_EARLY_EXIT_EN` not defined: always exactly W CALC cycles, giving fixed latency as above.

## Test plan

- Reset: `rst`=0 with `go`=1 and operands 15,15 → `cs`=0, `done`=0, `product`=0. Release reset → capture on first edge, `cs`=1.
- Max operands, W=4: 15×15, `go` pulsed one cycle → `done` after exactly 4 CALC edges, `product`=225, `done` high exactly one cycle, then `cs`=0.
- Exhaustive W=4: all 16×16 pairs with `go` held high, clocked until `done` → `product`=A·B each time; no `done` gaps other than the fixed latency.
- Zero operands: 0×13 → 0 after 4 CALC cycles. 9×0 → 0 after 4 CALC cycles (macro off) or 1 cycle to `done` (macro on).
- Early exit (macro on): 7×2 → `done` after 2 CALC edges, `product`=14. Same stimulus with macro off → 4 CALC edges, `product`=14.
- Abort: start 11×13, assert `rst` after 2 CALC edges → immediate `cs`=0, `product`=0. No `done` appears. A following 3×5 gives 15.

Source files
------------

// File: rtl/integer_multiplier_if.sv
// Start/result handshake bundle for integer_multiplier: go/operands in, product/done/cs out.
interface integer_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 go;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 done;
    logic [3:0]           cs;

    modport master (
        output go, multiplicand, multiplier,
        input  product, done, cs
    );

    modport slave (
        input  go, multiplicand, multiplier,
        output product, done, cs
    );
endinterface

// File: rtl/integer_multiplier.sv
// Shift-and-add unsigned multiplier, one multiplier bit per clock, go/done handshake.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module integer_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    integer_multiplier_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // state | meaning
    // IDLE  | waiting for go, product holds last result
    // CALC  | one shift-and-add step per clock
    // DONE  | product valid, done high for this single cycle
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        CALC = 4'd1,
        DONE = 4'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   s_q, s_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            s_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            s_q     <= s_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        s_d     = s_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    s_d     = {{WIDTH{1'b0}}, bus.multiplicand};
                    m_d     = bus.multiplier;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef MULT_EARLY_EXIT_EN
                    if (bus.multiplier == '0) state_d = DONE;
`endif
                end
            end
            CALC: begin
                // 2W-bit accumulator holds any W x W product, so no carry out is needed
                if (m_q[0]) p_d = p_q + s_q;
                s_d   = s_q << 1;
                m_d   = m_q >> 1;
                cnt_d = cnt_q + 1'b1;
`ifdef MULT_EARLY_EXIT_EN
                if ((cnt_q == LAST_CNT) || (m_d == '0)) state_d = DONE;
`else
                if (cnt_q == LAST_CNT) state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.done    = (state_q == DONE);
    assign bus.product = p_q;
    assign bus.cs      = state_q;
endmodule
